// File: rtl/dual_fetch_if.sv
// Downstream and instruction-memory signals of the dual-issue fetch unit.
// master drives control and memory data; slave is the fetch unit.
interface dual_fetch_if #(
    parameter int IMEM_AW = 11
);
    logic               stall;
    logic               consume1;
    logic               redirect;
    logic [12:0]        redirect_pc;
    logic [IMEM_AW-1:0] imem_addr1;
    logic [IMEM_AW-1:0] imem_addr2;
    logic [31:0]        imem_data1;
    logic [31:0]        imem_data2;
    logic [12:0]        pc1_out;
    logic [12:0]        pc2_out;
    logic [31:0]        inst1_out;
    logic [31:0]        inst2_out;
    logic               valid_out;
    logic [31:0]        fetch_cnt;

    modport master (
        output stall, consume1, redirect, redirect_pc,
        output imem_data1, imem_data2,
        input  imem_addr1, imem_addr2,
        input  pc1_out, pc2_out, inst1_out, inst2_out,
        input  valid_out, fetch_cnt
    );

    modport slave (
        input  stall, consume1, redirect, redirect_pc,
        input  imem_data1, imem_data2,
        output imem_addr1, imem_addr2,
        output pc1_out, pc2_out, inst1_out, inst2_out,
        output valid_out, fetch_cnt
    );
endinterface

// File: rtl/dual_fetch.sv
// Dual-issue instruction fetch: delivers an aligned pair of instructions
// per cycle from a dual-port synchronous-read instruction memory.
module dual_fetch #(
    parameter int IMEM_AW = 11
) (
    input logic         CLK,
    input logic         RST,
    dual_fetch_if.slave bus
);
    logic [12:0] pc_q;
    logic [12:0] npc;
    logic [12:0] npc_p4;
    logic        valid_q;
    logic [31:0] cnt_q;
    logic        kill_valid;
    logic        take;

    // The next-pair address goes straight to the memory so its data
    // lands in the same cycle pc_q takes that value.
    always_comb begin
        npc = pc_q;
        if (RST) begin
            npc = '0;
        end else if (bus.redirect) begin
            npc = {bus.redirect_pc[12:2], 2'b00};
        end else if (!valid_q || bus.stall) begin
            npc = pc_q;
        end else if (bus.consume1) begin
            npc = pc_q + 13'd4;
        end else begin
            npc = pc_q + 13'd8;
        end
    end

    assign npc_p4 = npc + 13'd4;

    assign bus.imem_addr1 = npc[IMEM_AW+1:2];
    assign bus.imem_addr2 = npc_p4[IMEM_AW+1:2];

    assign kill_valid    = valid_q & ~bus.redirect;
    assign take          = kill_valid & ~bus.stall;

    assign bus.valid_out = kill_valid;
    assign bus.pc1_out   = pc_q;
    assign bus.pc2_out   = pc_q + 13'd4;
    assign bus.inst1_out = valid_q ? bus.imem_data1 : 32'd0;
    assign bus.inst2_out = valid_q ? bus.imem_data2 : 32'd0;
    assign bus.fetch_cnt = cnt_q;

    always_ff @(posedge CLK) begin
        pc_q <= npc;
        if (RST) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b1;
            if (take) begin
                cnt_q <= cnt_q + (bus.consume1 ? 32'd1 : 32'd2);
            end
        end
    end
endmodule
